branch_predict_ctrl: RTL and testbench

- Branch prediction and resolution controller for the pipelined RV32 core.
- Holds a 2-bit saturating-counter branch history table (BHT) and supplies a taken/not-taken prediction plus target to IF.
- In EX, takes the branch comparator's resolved flag. On a misprediction it sequences the redirect and the pipeline flush, and it updates the BHT.

---
 rtl/branch_predict_ctrl_if.sv | 32 +++
 rtl/branch_predict_ctrl.sv | 123 ++++++++++++
 tb/tb_branch_predict_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_predict_ctrl_if.sv
// IF/EX-side signal bundle of the branch prediction controller.
// The master modport is the pipeline side; the slave modport is the controller.
interface branch_predict_ctrl_if;
    logic [31:0] if_pc;
    logic [4:0]  if_opcode;
    logic [31:0] if_imm;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [4:0]  ex_opcode;
    logic        ex_flag;
    logic        ex_pred_taken;
    logic [31:0] ex_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [15:0] mispredict_cnt;

    modport master (
        output if_pc, if_opcode, if_imm, stall, ex_valid, ex_pc, ex_opcode,
               ex_flag, ex_pred_taken, ex_target,
        input  pred_taken, pred_target, redirect, redirect_pc, flush, mispredict_cnt
    );

    modport slave (
        input  if_pc, if_opcode, if_imm, stall, ex_valid, ex_pc, ex_opcode,
               ex_flag, ex_pred_taken, ex_target,
        output pred_taken, pred_target, redirect, redirect_pc, flush, mispredict_cnt
    );
endinterface

// File: rtl/branch_predict_ctrl.sv
// 2-bit saturating-counter BHT predictor with EX-stage resolution,
// redirect generation and a multi-cycle flush sequencer.
module branch_predict_ctrl #(
    parameter int unsigned IDX_BITS     = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    branch_predict_ctrl_if.slave bp
);
    localparam int unsigned ENTRIES    = 1 << IDX_BITS;
    localparam logic [4:0]  OP_BRANCH  = 5'b11000;
    localparam logic [4:0]  OP_JAL     = 5'b11011;
    localparam logic [4:0]  OP_JALR    = 5'b11001;
    localparam logic [2:0]  FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    bht_q [ENTRIES];
    logic [2:0]    cnt_q, cnt_d;
    logic          redirect_q, redirect_d;
    logic [31:0]   rpc_q, rpc_d;
    logic          flush_q, flush_d;
    logic [15:0]   mcnt_q, mcnt_d;

    logic [IDX_BITS-1:0] if_idx, ex_idx;
    logic is_br, is_jal, is_jalr, resolve, actual, mispredict, pred;

    assign if_idx = bp.if_pc[IDX_BITS+1:2];
    assign ex_idx = bp.ex_pc[IDX_BITS+1:2];

    always_comb begin
        pred = 1'b0;
        case (bp.if_opcode)
            OP_BRANCH: pred = bht_q[if_idx][1];
            OP_JAL:    pred = 1'b1;
            default:   pred = 1'b0;
        endcase
    end

    assign bp.pred_taken  = pred;
    assign bp.pred_target = bp.if_pc + bp.if_imm;

    always_comb begin
        is_br   = (bp.ex_opcode == OP_BRANCH);
        is_jal  = (bp.ex_opcode == OP_JAL);
        is_jalr = (bp.ex_opcode == OP_JALR);
        resolve = bp.ex_valid & ~bp.stall & (state_q == IDLE);
        actual  = is_br ? bp.ex_flag : 1'b1;
        // A predicted-taken JALR still redirects: IF never knows its target.
        mispredict = resolve & (is_br | is_jal | is_jalr) &
                     ((actual != bp.ex_pred_taken) | (is_jalr & bp.ex_pred_taken));
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        redirect_d = 1'b0;
        rpc_d      = rpc_q;
        flush_d    = 1'b0;
        mcnt_d     = mcnt_q;
        case (state_q)
            IDLE: begin
                if (mispredict) begin
                    redirect_d = 1'b1;
                    rpc_d      = actual ? bp.ex_target : bp.ex_pc + 32'd4;
                    flush_d    = 1'b1;
                    cnt_d      = FLUSH_INIT;
                    mcnt_d     = mcnt_q + 16'd1;
                    if (FLUSH_CYCLES > 1) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (cnt_q == 3'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                    flush_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            redirect_q <= 1'b0;
            rpc_q      <= '0;
            flush_q    <= 1'b0;
            mcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            redirect_q <= redirect_d;
            rpc_q      <= rpc_d;
            flush_q    <= flush_d;
            mcnt_q     <= mcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) bht_q[i] <= 2'b01;
        end else if (resolve && is_br) begin
            if (bp.ex_flag) begin
                if (bht_q[ex_idx] != 2'b11) bht_q[ex_idx] <= bht_q[ex_idx] + 2'b01;
            end else begin
                if (bht_q[ex_idx] != 2'b00) bht_q[ex_idx] <= bht_q[ex_idx] - 2'b01;
            end
        end
    end

    assign bp.redirect       = redirect_q;
    assign bp.redirect_pc    = rpc_q;
    assign bp.flush          = flush_q;
    assign bp.mispredict_cnt = mcnt_q;
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Bench for branch_predict_ctrl: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the predictor.
module tb_branch_predict_ctrl;
    localparam int FC      = 2;
    localparam int NENT    = 16;
    localparam logic [4:0] OP_BR   = 5'b11000;
    localparam logic [4:0] OP_JAL  = 5'b11011;
    localparam logic [4:0] OP_JALR = 5'b11001;
    localparam logic [4:0] OP_ALU  = 5'b01100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_predict_ctrl_if bp ();
    branch_predict_ctrl_if bp1 ();

    branch_predict_ctrl #(.IDX_BITS(4), .FLUSH_CYCLES(FC)) u_dut (
        .clk(clk), .rst_n(rst_n), .bp(bp.slave)
    );
    branch_predict_ctrl #(.IDX_BITS(4), .FLUSH_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bp(bp1.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int          bht [NENT];
    logic        m_redirect;
    logic [31:0] m_rpc;
    logic        m_flush;
    int          flush_left;
    logic [15:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) bht[i] = 1;
        m_redirect = 1'b0; m_rpc = '0; m_flush = 1'b0; flush_left = 0; m_cnt = '0;
    endtask

    function automatic logic model_pred(input logic [4:0] op, input logic [31:0] pc);
        if (op == OP_BR)  return bht[(pc >> 2) % NENT] >= 2;
        if (op == OP_JAL) return 1'b1;
        return 1'b0;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit accept, relevant, act, misp;
        int idx;
        if (!rst_n) begin
            model_reset();
            return;
        end
        accept   = bp.ex_valid && !bp.stall && !(FC > 1 && flush_left > 0);
        relevant = bp.ex_opcode inside {OP_BR, OP_JAL, OP_JALR};
        act      = (bp.ex_opcode == OP_BR) ? bp.ex_flag : 1'b1;
        misp     = accept && relevant &&
                   (act != bp.ex_pred_taken || (bp.ex_opcode == OP_JALR && bp.ex_pred_taken));
        if (accept && bp.ex_opcode == OP_BR) begin
            idx = (bp.ex_pc >> 2) % NENT;
            if (bp.ex_flag) bht[idx] = (bht[idx] < 3) ? bht[idx] + 1 : 3;
            else            bht[idx] = (bht[idx] > 0) ? bht[idx] - 1 : 0;
        end
        if (misp) begin
            m_redirect = 1'b1;
            m_rpc      = act ? bp.ex_target : bp.ex_pc + 32'd4;
            flush_left = FC;
            m_cnt      = m_cnt + 16'd1;
        end else begin
            m_redirect = 1'b0;
            if (flush_left > 0) flush_left--;
        end
        m_flush = flush_left > 0;
    endtask

    task automatic tick();
        #1;
        check("pred_taken", bp.pred_taken, model_pred(bp.if_opcode, bp.if_pc));
        check("pred_target", bp.pred_target, bp.if_pc + bp.if_imm);
        model_edge();
        @(posedge clk); #1;
        check("redirect", bp.redirect, m_redirect);
        check("redirect_pc", bp.redirect_pc, m_rpc);
        check("flush", bp.flush, m_flush);
        check("mispredict_cnt", bp.mispredict_cnt, m_cnt);
    endtask

    task automatic idle();
        bp.ex_valid = 1'b0; bp.stall = 1'b0; bp.ex_pc = '0; bp.ex_opcode = OP_ALU;
        bp.ex_flag = 1'b0; bp.ex_pred_taken = 1'b0; bp.ex_target = '0;
    endtask

    task automatic resolve(input logic [4:0] op, input logic [31:0] pc, input logic flag,
                           input logic pred, input logic [31:0] tgt);
        bp.ex_valid = 1'b1; bp.ex_opcode = op; bp.ex_pc = pc; bp.ex_flag = flag;
        bp.ex_pred_taken = pred; bp.ex_target = tgt;
    endtask

    task automatic if_probe(input string tag, input logic [31:0] pc, input logic exp);
        bp.if_pc = pc; bp.if_opcode = OP_BR; bp.if_imm = 32'h10;
        #1 check(tag, bp.pred_taken, exp);
    endtask

    initial begin
        model_reset();
        bp.if_pc = '0; bp.if_opcode = OP_ALU; bp.if_imm = '0;
        idle();
        bp1.if_pc = '0; bp1.if_opcode = OP_ALU; bp1.if_imm = '0;
        bp1.stall = 1'b0; bp1.ex_valid = 1'b0; bp1.ex_pc = '0; bp1.ex_opcode = OP_ALU;
        bp1.ex_flag = 1'b0; bp1.ex_pred_taken = 1'b0; bp1.ex_target = '0;

        rst_n = 1'b0; tick(); tick();
        check("rst_redirect", bp.redirect, 32'd0);
        check("rst_flush", bp.flush, 32'd0);
        check("rst_cnt", bp.mispredict_cnt, 32'd0);
        rst_n = 1'b1;
        if_probe("rst_bht_weak_nt", 32'h40, 1'b0);

        resolve(OP_BR, 32'h40, 1'b1, 1'b0, 32'h80); tick();
        check("mp_redirect", bp.redirect, 32'd1);
        check("mp_rpc_taken", bp.redirect_pc, 32'h80);
        check("mp_cnt", bp.mispredict_cnt, 32'd1);
        idle(); tick();
        check("mp_flush2", bp.flush, 32'd1);
        check("mp_redirect_1cyc", bp.redirect, 32'd0);
        tick();
        check("mp_flush_end", bp.flush, 32'd0);
        if_probe("bht0_taken", 32'h40, 1'b1);

        resolve(OP_BR, 32'h44, 1'b0, 1'b1, 32'h999); tick();
        check("mp_rpc_fallthru", bp.redirect_pc, 32'h48);
        idle(); tick(); tick();

        for (int i = 0; i < 4; i++) begin resolve(OP_BR, 32'h10, 1'b1, 1'b1, 32'h20); tick(); end
        idle(); if_probe("sat_high", 32'h10, 1'b1);
        for (int i = 0; i < 4; i++) begin resolve(OP_BR, 32'h10, 1'b0, 1'b0, 32'h20); tick(); end
        idle(); if_probe("sat_low", 32'h10, 1'b0);
        check("sat_no_mp", bp.mispredict_cnt, 32'd2);

        resolve(OP_BR, 32'h40, 1'b1, 1'b0, 32'h100); tick();
        resolve(OP_BR, 32'h40, 1'b1, 1'b0, 32'h300); tick();
        check("flush_ignore_redirect", bp.redirect, 32'd0);
        check("flush_ignore_cnt", bp.mispredict_cnt, 32'd3);
        idle(); tick();
        resolve(OP_BR, 32'h40, 1'b1, 1'b0, 32'h300); bp.stall = 1'b1; tick();
        check("stall_ignore", bp.redirect, 32'd0);
        idle(); tick();

        resolve(OP_JAL, 32'h50, 1'b0, 1'b1, 32'h500); tick();
        check("jal_no_redirect", bp.redirect, 32'd0);
        resolve(OP_JALR, 32'h54, 1'b0, 1'b0, 32'h200); tick();
        check("jalr_redirect", bp.redirect, 32'd1);
        check("jalr_rpc", bp.redirect_pc, 32'h200);
        idle(); tick(); tick();

        resolve(OP_BR, 32'h40, 1'b0, 1'b1, 32'h0); tick();
        idle(); rst_n = 1'b0; tick();
        check("rst_mid_flush", bp.flush, 32'd0);
        rst_n = 1'b1;
        if_probe("rst_mid_bht", 32'h10, 1'b0);

        resolve(OP_BR, 32'h10, 1'b1, 1'b1, 32'h0);
        if_probe("rw_same_old", 32'h10, 1'b0);
        tick();
        if_probe("rw_same_new", 32'h10, 1'b1);
        idle();

        for (int n = 0; n < 400; n++) begin
            bp.if_pc     = $urandom_range(0, 63) << 2;
            bp.if_imm    = $urandom;
            case ($urandom_range(0, 3))
                0: bp.if_opcode = OP_BR; 1: bp.if_opcode = OP_JAL;
                2: bp.if_opcode = OP_JALR; default: bp.if_opcode = OP_ALU;
            endcase
            bp.ex_valid      = $urandom_range(0, 3) != 0;
            bp.stall         = $urandom_range(0, 4) == 0;
            bp.ex_pc         = $urandom_range(0, 63) << 2;
            case ($urandom_range(0, 5))
                0, 1, 2: bp.ex_opcode = OP_BR; 3: bp.ex_opcode = OP_JAL;
                4: bp.ex_opcode = OP_JALR; default: bp.ex_opcode = OP_ALU;
            endcase
            bp.ex_flag       = $urandom_range(0, 1);
            bp.ex_pred_taken = $urandom_range(0, 1);
            bp.ex_target     = $urandom;
            rst_n            = $urandom_range(0, 63) != 0;
            tick();
        end
        rst_n = 1'b1; idle();

        #1 check("wrap_start", bp1.mispredict_cnt, 32'd0);
        bp1.ex_valid = 1'b1; bp1.ex_opcode = OP_JALR; bp1.ex_pred_taken = 1'b1;
        bp1.ex_pc = 32'h60; bp1.ex_target = 32'h700;
        for (int n = 0; n < 65535; n++) @(posedge clk);
        #1;
        check("wrap_ffff", bp1.mispredict_cnt, 32'hffff);
        check("fc1_flush", bp1.flush, 32'd1);
        check("fc1_rpc", bp1.redirect_pc, 32'h700);
        @(posedge clk); #1;
        check("wrap_zero", bp1.mispredict_cnt, 32'd0);
        bp1.ex_valid = 1'b0;
        @(posedge clk); #1;
        check("fc1_flush_end", bp1.flush, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
